// File: rtl/cvita_dest_lookup_2lvl_if.sv
// AXI-Stream style bundle for the CVITA lookup block.
// The upstream side (slave) carries no tdest; the downstream side (master) adds it.
interface cvita_dest_lookup_2lvl_if #(
    parameter int DEST_WIDTH = 4
);
    logic [63:0]           tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;
    logic [DEST_WIDTH-1:0] tdest;

    modport master (output tdata, output tlast, output tvalid, output tdest, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cvita_dest_lookup_2lvl.sv
// Two-level CVITA destination lookup: LOCAL table by endpoint when the SID address
// matches my_addr, otherwise REMOTE table by address; misses use a default or drop.
module cvita_dest_lookup_2lvl #(
    parameter int DEST_WIDTH   = 4,
    parameter int DEFAULT_DEST = 0,
    parameter bit DROP_ON_MISS = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        set_stb,
    input  logic [8:0]                  set_addr,
    input  logic [DEST_WIDTH:0]         set_data,
    input  logic [7:0]                  my_addr,
    cvita_dest_lookup_2lvl_if.slave     i_s,
    cvita_dest_lookup_2lvl_if.master    o_m,
    output logic [15:0]                 miss_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_FWD,
        S_DROP
    } state_t;

    state_t                r_state;
    state_t                w_next;

    // Both tables share one 512-entry space: index[8] selects LOCAL (0) or REMOTE (1).
    logic [DEST_WIDTH-1:0] r_ram [0:511];
    logic [511:0]          r_vld;
    logic [DEST_WIDTH-1:0] r_rd_dest;
    logic                  r_rd_vld;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [15:0]           r_miss_count;

    logic                  w_is_local;
    logic [8:0]            w_rd_addr;
    logic                  w_rd_en;
    logic                  w_in_ready;
    logic                  w_out_valid;

    assign w_is_local = (i_s.tdata[15:8] == my_addr);
    assign w_rd_addr  = w_is_local ? {1'b0, i_s.tdata[7:0]} : {1'b1, i_s.tdata[15:8]};
    assign w_rd_en    = (r_state == S_IDLE) && i_s.tvalid;

    // NOTE: dest storage is a plain RAM with no reset so it maps onto block memory;
    // only the valid bits are flops and get cleared.
    always_ff @(posedge clk) begin
        if (set_stb) begin
            r_ram[set_addr] <= set_data[DEST_WIDTH-1:0];
        end
        if (w_rd_en) begin
            r_rd_dest <= r_ram[w_rd_addr];
        end
    end

    // NOTE: non-blocking assignments give read-before-write on a same-cycle hit
    // of the index being written, matching the RAM behaviour above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            if (set_stb) begin
                r_vld[set_addr] <= set_data[DEST_WIDTH];
            end
            if (w_rd_en) begin
                r_rd_vld <= r_vld[w_rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_s.tvalid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (r_rd_vld || !DROP_ON_MISS) begin
                    w_next = S_FWD;
                end else begin
                    w_next = S_DROP;
                end
            end
            S_FWD: begin
                w_out_valid = i_s.tvalid;
                w_in_ready  = o_m.tready;
                if (i_s.tvalid && o_m.tready && i_s.tlast) begin
                    w_next = S_IDLE;
                end
            end
            S_DROP: begin
                w_in_ready = 1'b1;
                if (i_s.tvalid && i_s.tlast) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // tdest is only loaded leaving LOOKUP, so it holds for the whole packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdest      <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (r_rd_vld) begin
                r_tdest <= r_rd_dest;
            end else begin
                r_miss_count <= r_miss_count + 16'd1;
                if (!DROP_ON_MISS) begin
                    r_tdest <= DEST_WIDTH'(DEFAULT_DEST);
                end
            end
        end
    end

    assign o_m.tdata  = i_s.tdata;
    assign o_m.tlast  = i_s.tlast;
    assign o_m.tvalid = w_out_valid;
    assign o_m.tdest  = r_tdest;
    assign i_s.tready = w_in_ready;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cvita_dest_lookup_2lvl.sv
// Bench for cvita_dest_lookup_2lvl: a forwarding instance (default 0xF) and a dropping
// instance share the table-write and stream stimulus; the selected one is observed.
module tb_cvita_dest_lookup_2lvl;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          set_stb = 1'b0;
    logic [8:0]    set_addr = '0;
    logic [DW:0]   set_data = '0;
    logic [7:0]    my_addr = '0;
    logic [63:0]   in_tdata = '0;
    logic          in_tlast = 1'b0;
    logic          in_tvalid = 1'b0;
    logic          out_tready = 1'b0;
    logic          sel_d = 1'b0;
    logic [15:0]   miss_f, miss_d;

    int            n_checks = 0;
    int            n_err = 0;
    int            rdy_mode = 0;
    bit            mw_en = 1'b0;
    int            mw_cyc = 0;
    logic [8:0]    mw_addr = '0;
    logic [DW:0]   mw_data = '0;

    always #5 clk = ~clk;

    cvita_dest_lookup_2lvl_if #(.DEST_WIDTH(DW)) f_in ();
    cvita_dest_lookup_2lvl_if #(.DEST_WIDTH(DW)) f_out ();
    cvita_dest_lookup_2lvl_if #(.DEST_WIDTH(DW)) d_in ();
    cvita_dest_lookup_2lvl_if #(.DEST_WIDTH(DW)) d_out ();

    assign f_in.tdata   = in_tdata;
    assign f_in.tlast   = in_tlast;
    assign f_in.tvalid  = in_tvalid && !sel_d;
    assign f_in.tdest   = '0;
    assign f_out.tready = out_tready && !sel_d;
    assign d_in.tdata   = in_tdata;
    assign d_in.tlast   = in_tlast;
    assign d_in.tvalid  = in_tvalid && sel_d;
    assign d_in.tdest   = '0;
    assign d_out.tready = out_tready && sel_d;

    logic          o_tvalid, o_tlast, i_tready;
    logic [63:0]   o_tdata;
    logic [DW-1:0] o_tdest;
    logic [15:0]   miss_sel;
    assign o_tvalid = sel_d ? d_out.tvalid : f_out.tvalid;
    assign o_tlast  = sel_d ? d_out.tlast  : f_out.tlast;
    assign o_tdata  = sel_d ? d_out.tdata  : f_out.tdata;
    assign o_tdest  = sel_d ? d_out.tdest  : f_out.tdest;
    assign i_tready = sel_d ? d_in.tready  : f_in.tready;
    assign miss_sel = sel_d ? miss_d : miss_f;

    cvita_dest_lookup_2lvl #(.DEST_WIDTH(DW), .DEFAULT_DEST(15), .DROP_ON_MISS(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .my_addr(my_addr), .i_s(f_in), .o_m(f_out), .miss_count(miss_f));

    cvita_dest_lookup_2lvl #(.DEST_WIDTH(DW), .DEFAULT_DEST(5), .DROP_ON_MISS(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .my_addr(my_addr), .i_s(d_in), .o_m(d_out), .miss_count(miss_d));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic next_ready();
        if (rdy_mode == 1) return !out_tready;
        if (rdy_mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic write_tbl(input bit remote, input logic [7:0] idx, input bit vld, input logic [DW-1:0] dest);
        set_stb  = 1'b1;
        set_addr = {remote, idx};
        set_data = {vld, dest};
        @(posedge clk); #1;
        set_stb  = 1'b0;
    endtask

    // Sends one packet (called at posedge+1) and checks every output beat.
    task automatic send_pkt(input logic [15:0] sid, input int n, input bit exp_fwd,
                            input logic [DW-1:0] exp_dest, input bit chk_lat, input string name);
        logic [63:0] beats[$];
        logic [63:0] b;
        int idx = 0, oidx = 0, cyc = 0, first = -1, nval = 0;
        bit ix, ox;
        for (int k = 0; k < n; k++) begin
            b = {$urandom, $urandom};
            if (k == 0) b[15:0] = sid;
            beats.push_back(b);
        end
        in_tvalid  = 1'b1;
        in_tdata   = beats[0];
        in_tlast   = (n == 1);
        out_tready = next_ready();
        while (idx < n && cyc < 300) begin
            @(negedge clk);
            ix = in_tvalid && i_tready;
            ox = o_tvalid && out_tready;
            if (o_tvalid) begin
                nval++;
                if (first < 0) first = cyc;
                if (exp_fwd) begin
                    check({name, " tdest"}, 64'(o_tdest), 64'(exp_dest));
                    if (oidx < n) begin
                        check({name, " tdata"}, o_tdata, beats[oidx]);
                        check({name, " tlast"}, 64'(o_tlast), 64'(oidx == n - 1));
                    end else begin
                        check({name, " extra beat"}, 64'(oidx), 64'(n - 1));
                    end
                end
            end
            if (ox) oidx++;
            if (ix) idx++;
            @(posedge clk); #1;
            set_stb  = mw_en && (cyc == mw_cyc);
            set_addr = mw_addr;
            set_data = mw_data;
            cyc++;
            if (idx < n) begin
                in_tdata = beats[idx];
                in_tlast = (idx == n - 1);
            end else begin
                in_tvalid = 1'b0;
                in_tlast  = 1'b0;
            end
            out_tready = next_ready();
        end
        set_stb   = 1'b0;
        mw_en     = 1'b0;
        in_tvalid = 1'b0;
        check({name, " beats consumed"}, 64'(idx), 64'(n));
        check({name, " beats out"}, 64'(oidx), exp_fwd ? 64'(n) : 64'd0);
        if (!exp_fwd) check({name, " tvalid seen"}, 64'(nval), 64'd0);
        if (exp_fwd && chk_lat) check({name, " first tvalid cycle"}, 64'(first), 64'd2);
    endtask

    task automatic do_reset();
        in_tvalid = 1'b0;
        set_stb   = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          use_d;
        logic [7:0]  my;
        logic [15:0] sid;
        int          n;
        bit          fwd;
        logic [3:0]  dest;
        int          miss;
    } vec_t;

    vec_t vecs[9];

    // Behavioural reference: two lookup arrays and a miss counter.
    bit          m_loc_v [256];
    logic [3:0]  m_loc_d [256];
    bit          m_rem_v [256];
    logic [3:0]  m_rem_d [256];
    int          m_miss;

    initial begin
        logic [7:0]  addrs[4];
        logic [15:0] sid;
        logic [7:0]  idx;
        logic [3:0]  d, exp_d;
        bit          v, rem, hit;
        int          k, cyc;

        vecs[0] = '{1'b0, 8'h02, 16'h0205, 4, 1'b1, 4'h3, 0};
        vecs[1] = '{1'b0, 8'h02, 16'h0711, 3, 1'b1, 4'h9, 0};
        vecs[2] = '{1'b0, 8'h02, 16'h0233, 2, 1'b1, 4'hF, 1};
        vecs[3] = '{1'b0, 8'h02, 16'h0210, 1, 1'b1, 4'hF, 2};
        vecs[4] = '{1'b0, 8'h07, 16'h0711, 1, 1'b1, 4'hF, 3};
        vecs[5] = '{1'b0, 8'h01, 16'hFE00, 2, 1'b1, 4'hC, 3};
        vecs[6] = '{1'b1, 8'h02, 16'h0299, 3, 1'b0, 4'h0, 1};
        vecs[7] = '{1'b1, 8'h02, 16'h0205, 2, 1'b1, 4'h3, 1};
        vecs[8] = '{1'b1, 8'h02, 16'h0800, 1, 1'b0, 4'h0, 2};

        // Reset state of both instances.
        #2;
        check("rst f tvalid", 64'(f_out.tvalid), 64'd0);
        check("rst f tready", 64'(f_in.tready), 64'd0);
        check("rst f tdest", 64'(f_out.tdest), 64'd0);
        check("rst f miss", 64'(miss_f), 64'd0);
        check("rst d tready", 64'(d_in.tready), 64'd0);
        check("rst d miss", 64'(miss_d), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        write_tbl(1'b0, 8'h05, 1'b1, 4'h3);
        write_tbl(1'b1, 8'h07, 1'b1, 4'h9);
        write_tbl(1'b0, 8'h10, 1'b0, 4'h7);
        write_tbl(1'b1, 8'hFE, 1'b1, 4'hC);

        rdy_mode = 0;
        for (int i = 0; i < 9; i++) begin
            sel_d   = vecs[i].use_d;
            my_addr = vecs[i].my;
            send_pkt(vecs[i].sid, vecs[i].n, vecs[i].fwd, vecs[i].dest, 1'b1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d miss_count", i), 64'(miss_sel), 64'(vecs[i].miss));
        end

        // Table write during a packet must not move tdest; the next packet sees it.
        sel_d   = 1'b0;
        my_addr = 8'h02;
        mw_en   = 1'b1;
        mw_cyc  = 3;
        mw_addr = {1'b1, 8'h07};
        mw_data = {1'b1, 4'h4};
        send_pkt(16'h0711, 4, 1'b1, 4'h9, 1'b1, "midwrite");
        send_pkt(16'h0711, 2, 1'b1, 4'h4, 1'b1, "after_write");

        // Back-to-back single-beat packets with o_tready toggling.
        rdy_mode = 1;
        send_pkt(16'h0205, 1, 1'b1, 4'h3, 1'b0, "b2b0");
        send_pkt(16'h0711, 1, 1'b1, 4'h4, 1'b0, "b2b1");
        send_pkt(16'h0233, 1, 1'b1, 4'hF, 1'b0, "b2b2");
        send_pkt(16'hFE00, 1, 1'b1, 4'hC, 1'b0, "b2b3");
        check("b2b miss_count", 64'(miss_f), 64'd4);

        // Reset on beat 2 of a 5-beat packet.
        rdy_mode   = 0;
        out_tready = 1'b1;
        in_tvalid  = 1'b1;
        in_tdata   = {48'h0, 16'h0205};
        in_tlast   = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 2 && cyc < 50) begin
            @(negedge clk);
            if (in_tvalid && i_tready) k++;
            @(posedge clk); #1;
            cyc++;
            in_tdata = 64'(k) + 64'h100;
        end
        check("rst_mid beats before reset", 64'(k), 64'd2);
        check("rst_mid tdest before reset", 64'(o_tdest), 64'h3);
        rst_n = 1'b0;
        #1;
        check("rst_mid tvalid", 64'(o_tvalid), 64'd0);
        check("rst_mid tready", 64'(i_tready), 64'd0);
        check("rst_mid tdest", 64'(o_tdest), 64'd0);
        check("rst_mid miss", 64'(miss_f), 64'd0);
        in_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(16'h0205, 2, 1'b1, 4'hF, 1'b1, "rst_prior_hit");
        check("rst_prior_hit miss", 64'(miss_f), 64'd1);

        // Randomised traffic against the reference arrays.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            m_loc_v[i] = 1'b0;
            m_rem_v[i] = 1'b0;
            m_loc_d[i] = '0;
            m_rem_d[i] = '0;
        end
        m_miss   = 0;
        addrs[0] = 8'h02;
        addrs[1] = 8'h05;
        addrs[2] = 8'h07;
        addrs[3] = 8'h09;
        rdy_mode = 2;
        sel_d    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rem = $urandom_range(0, 1) == 1;
                idx = rem ? addrs[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
                v   = $urandom_range(0, 3) != 0;
                d   = 4'($urandom_range(0, 15));
                write_tbl(rem, idx, v, d);
                if (rem) begin
                    m_rem_v[idx] = v;
                    m_rem_d[idx] = d;
                end else begin
                    m_loc_v[idx] = v;
                    m_loc_d[idx] = d;
                end
            end
            my_addr = ($urandom_range(0, 1) == 1) ? 8'h05 : 8'h02;
            sid     = {addrs[$urandom_range(0, 3)], 8'($urandom_range(0, 7))};
            if (sid[15:8] == my_addr) begin
                hit   = m_loc_v[sid[7:0]];
                exp_d = m_loc_d[sid[7:0]];
            end else begin
                hit   = m_rem_v[sid[15:8]];
                exp_d = m_rem_d[sid[15:8]];
            end
            if (!hit) begin
                exp_d = 4'hF;
                m_miss++;
            end
            send_pkt(sid, $urandom_range(1, 4), 1'b1, exp_d, 1'b0, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d miss_count", i), 64'(miss_f), 64'(m_miss));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
